// File: rtl/tt_um_jimktrains_vslc_pwm_capture.sv
// VSLC PWM/servo capture.
// Measures high-time and rise-to-rise period of a pulse train on an
// asynchronous pin, decodes each pulse to a bit against a threshold, and
// flags loss of signal. Results come with a one-cycle sample_valid strobe.
// Optional feature macro: PWM_CAPTURE_DEGLITCH_EN adds a DEGLITCH_LEN-cycle
// stability filter between the synchronizer and the edge detector.
module tt_um_jimktrains_vslc_pwm_capture #(
  parameter int DEGLITCH_LEN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture_enabled,
  input  logic        pwm_in,
  input  logic [15:0] threshold_val,
  input  logic [15:0] timeout_val,
  output logic [15:0] high_width,
  output logic [15:0] period,
  output logic        decoded_value,
  output logic        sample_valid,
  output logic        timeout_flag,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

  // Cycles after reset/enable before the pipeline holds real pin samples.
  // Until then the reset zeros in the synchronizer would look like a low pin
  // and a line stuck high would arm and then produce a false rise.
`ifdef PWM_CAPTURE_DEGLITCH_EN
  localparam int SETTLE = 3 + DEGLITCH_LEN;
`else
  localparam int SETTLE = 3;
`endif
  localparam int SETTLE_W = $clog2(SETTLE + 1);

  if (DEGLITCH_LEN < 1) begin : g_bad_deglitch_len
    $error("DEGLITCH_LEN must be at least 1");
  end

  state_t              state;
  logic                sync_p0;
  logic                sync_p1;
  logic                lvl;
  logic                lvl_d;
  logic                rise;
  logic                fall;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                settled;
  logic [15:0]         cnt;
  logic [15:0]         cnt_inc;
  logic [15:0]         hw_tmp;
  logic                tmo_hit;

  // Two-flop synchronizer, edge-detect delay and pipeline settle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      lvl_d      <= 1'b0;
      settle_cnt <= '0;
    end else if (!capture_enabled) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      lvl_d      <= 1'b0;
      settle_cnt <= '0;
    end else begin
      sync_p0 <= pwm_in;
      sync_p1 <= sync_p0;
      lvl_d   <= lvl;
      if (settle_cnt != SETTLE_W'(SETTLE)) begin
        settle_cnt <= settle_cnt + 1'b1;
      end
    end
  end

`ifdef PWM_CAPTURE_DEGLITCH_EN
  localparam int DG_W = (DEGLITCH_LEN > 1) ? $clog2(DEGLITCH_LEN) : 1;

  logic [DG_W-1:0] dg_cnt;

  // Accept a new level only after it has held for DEGLITCH_LEN cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dg_cnt <= '0;
      lvl    <= 1'b0;
    end else if (!capture_enabled) begin
      dg_cnt <= '0;
      lvl    <= 1'b0;
    end else if (sync_p1 == lvl) begin
      dg_cnt <= '0;
    end else if (dg_cnt == DG_W'(DEGLITCH_LEN - 1)) begin
      dg_cnt <= '0;
      lvl    <= sync_p1;
    end else begin
      dg_cnt <= dg_cnt + 1'b1;
    end
  end
`else
  assign lvl = sync_p1;
`endif

  assign rise    = lvl & ~lvl_d;
  assign fall    = ~lvl & lvl_d;
  assign settled = (settle_cnt == SETTLE_W'(SETTLE));
  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign tmo_hit = (timeout_val != 16'd0) && (cnt == timeout_val);

  // Measurement FSM with registered results, strobe and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      hw_tmp        <= '0;
      high_width    <= '0;
      period        <= '0;
      decoded_value <= 1'b0;
      sample_valid  <= 1'b0;
      timeout_flag  <= 1'b0;
      busy          <= 1'b0;
    end else if (!capture_enabled) begin
      state         <= IDLE;
      cnt           <= '0;
      hw_tmp        <= '0;
      high_width    <= '0;
      period        <= '0;
      decoded_value <= 1'b0;
      sample_valid  <= 1'b0;
      timeout_flag  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (settled && !lvl) begin
            state <= ARMED;
          end
        end
        ARMED: begin
          if (rise) begin
            cnt   <= 16'd1;
            busy  <= 1'b1;
            state <= HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            hw_tmp <= cnt;
            cnt    <= cnt_inc;
            state  <= LOW;
          end else if (tmo_hit) begin
            timeout_flag <= 1'b1;
            cnt          <= '0;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        LOW: begin
          if (rise) begin
            period        <= cnt;
            high_width    <= hw_tmp;
            decoded_value <= (hw_tmp >= threshold_val);
            sample_valid  <= 1'b1;
            timeout_flag  <= 1'b0;
            cnt           <= 16'd1;
            state         <= HIGH;
          end else if (tmo_hit) begin
            timeout_flag <= 1'b1;
            cnt          <= '0;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_pwm_capture.sv
// Self-checking bench for tt_um_jimktrains_vslc_pwm_capture.
// Drives pulse trains segment by segment, records the cycle of every pin
// edge, and derives the expected samples from those edge times.
module tb_tt_um_jimktrains_vslc_pwm_capture;

  localparam int DG = 4;
`ifdef PWM_CAPTURE_DEGLITCH_EN
  localparam int LAT  = 3 + DG;
  localparam bit GREC = 1'b0;
`else
  localparam int LAT  = 3;
  localparam bit GREC = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        capture_enabled;
  logic        pwm_in;
  logic [15:0] threshold_val;
  logic [15:0] timeout_val;
  logic [15:0] high_width;
  logic [15:0] period;
  logic        decoded_value;
  logic        sample_valid;
  logic        timeout_flag;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // observed samples
  int          s_cyc[$];
  logic [15:0] s_hw[$];
  logic [15:0] s_per[$];
  logic        s_dec[$];
  // recorded pin edges
  int          r_cyc[$];
  logic [15:0] r_thr[$];
  int          f_cyc[$];
  // expected samples
  int          e_cyc[$];
  logic [15:0] e_hw[$];
  logic [15:0] e_per[$];
  logic        e_dec[$];

  tt_um_jimktrains_vslc_pwm_capture #(.DEGLITCH_LEN(DG)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .capture_enabled(capture_enabled),
    .pwm_in         (pwm_in),
    .threshold_val  (threshold_val),
    .timeout_val    (timeout_val),
    .high_width     (high_width),
    .period         (period),
    .decoded_value  (decoded_value),
    .sample_valid   (sample_valid),
    .timeout_flag   (timeout_flag),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      s_cyc.push_back(cyc);
      s_hw.push_back(high_width);
      s_per.push_back(period);
      s_dec.push_back(decoded_value);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Hold the pin at lvl for n clocks; called just after a falling edge.
  task automatic seg(input logic lvl, input int n, input bit rec);
    if (rec && (lvl !== pwm_in)) begin
      if (lvl) begin
        r_cyc.push_back(cyc);
        r_thr.push_back(threshold_val);
      end else begin
        f_cyc.push_back(cyc);
      end
    end
    pwm_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_rec();
    s_cyc.delete(); s_hw.delete(); s_per.delete(); s_dec.delete();
    r_cyc.delete(); r_thr.delete(); f_cyc.delete();
  endtask

  // Each rise after the first publishes the previous pulse: high time is
  // first fall minus previous rise, period is rise minus previous rise.
  function automatic void build_expected();
    e_cyc.delete(); e_hw.delete(); e_per.delete(); e_dec.delete();
    for (int j = 1; j < r_cyc.size(); j++) begin
      int hw;
      hw = -1;
      for (int k = 0; k < f_cyc.size(); k++) begin
        if (hw < 0 && f_cyc[k] > r_cyc[j-1] && f_cyc[k] < r_cyc[j]) hw = f_cyc[k] - r_cyc[j-1];
      end
      if (hw >= 0) begin
        e_cyc.push_back(r_cyc[j] + LAT);
        e_hw.push_back(16'(hw));
        e_per.push_back(16'(r_cyc[j] - r_cyc[j-1]));
        e_dec.push_back(16'(hw) >= r_thr[j]);
      end
    end
  endfunction

  task automatic restart();
    @(negedge clk);
    capture_enabled = 1'b0;
    pwm_in          = 1'b0;
    timeout_val     = 16'd0;
    repeat (3) @(negedge clk);
    capture_enabled = 1'b1;
    clear_rec();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    int seen;
    rst_n = 1'b0; capture_enabled = 1'b1; pwm_in = 1'b1;
    threshold_val = 16'd0; timeout_val = 16'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({high_width, period, decoded_value, sample_valid, timeout_flag, busy} !== 36'd0) begin
      bad++;
      $display("FAIL reset_outputs: got hw=%0d per=%0d dec=%0b sv=%0b tmo=%0b busy=%0b, required all 0",
               high_width, period, decoded_value, sample_valid, timeout_flag, busy);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || sample_valid !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL stuck_high_idle: got %0d cycles with busy/sample_valid, required 0", seen);
    end
    total++;
    if ({high_width, period, decoded_value, timeout_flag} !== 34'd0) begin
      bad++;
      $display("FAIL stuck_high_outputs: got hw=%0d per=%0d dec=%0b tmo=%0b, required all 0",
               high_width, period, decoded_value, timeout_flag);
    end
  endtask

  task automatic test_random_train();
    restart();
    threshold_val = 16'($urandom_range(10, 140));
    seg(1'b0, 20, 1'b1);
    for (int p = 0; p < 8; p++) begin
      seg(1'b1, $urandom_range(8, 150), 1'b1);
      seg(1'b0, $urandom_range(8, 150), 1'b1);
    end
    seg(1'b1, LAT + 5, 1'b1);
    build_expected();
    total++;
    if (s_cyc.size() != e_cyc.size()) begin
      bad++;
      $display("FAIL random_count: got %0d samples, required %0d", s_cyc.size(), e_cyc.size());
    end
    for (int i = 0; i < e_cyc.size() && i < s_cyc.size(); i++) begin
      total++;
      if (s_cyc[i] != e_cyc[i] || s_hw[i] !== e_hw[i] || s_per[i] !== e_per[i] || s_dec[i] !== e_dec[i]) begin
        bad++;
        $display("FAIL random_sample[%0d]: got cyc=%0d hw=%0d per=%0d dec=%0b, required cyc=%0d hw=%0d per=%0d dec=%0b",
                 i, s_cyc[i], s_hw[i], s_per[i], s_dec[i], e_cyc[i], e_hw[i], e_per[i], e_dec[i]);
      end
    end
  endtask

  task automatic test_clean_train();
    restart();
    threshold_val = 16'd50;
    seg(1'b0, 20, 1'b1);
    for (int p = 0; p < 4; p++) begin seg(1'b1, 20, 1'b1); seg(1'b0, 80, 1'b1); end
    for (int p = 0; p < 2; p++) begin seg(1'b1, 60, 1'b1); seg(1'b0, 40, 1'b1); end
    seg(1'b1, LAT + 5, 1'b1);
    build_expected();
    total++;
    if (s_cyc.size() != 6 || e_cyc.size() != 6) begin
      bad++;
      $display("FAIL clean_count: got %0d samples (model %0d), required 6", s_cyc.size(), e_cyc.size());
    end
    for (int i = 0; i < e_cyc.size() && i < s_cyc.size(); i++) begin
      total++;
      if (s_cyc[i] != e_cyc[i] || s_hw[i] !== e_hw[i] || s_per[i] !== e_per[i] || s_dec[i] !== e_dec[i]) begin
        bad++;
        $display("FAIL clean_sample[%0d]: got cyc=%0d hw=%0d per=%0d dec=%0b, required cyc=%0d hw=%0d per=%0d dec=%0b",
                 i, s_cyc[i], s_hw[i], s_per[i], s_dec[i], e_cyc[i], e_hw[i], e_per[i], e_dec[i]);
      end
    end
    if (s_cyc.size() == 6) begin
      total++;
      if (s_hw[0] !== 16'd20 || s_per[0] !== 16'd100 || s_dec[0] !== 1'b0 || s_hw[5] !== 16'd60 || s_dec[5] !== 1'b1) begin
        bad++;
        $display("FAIL clean_values: got first hw=%0d per=%0d dec=%0b last hw=%0d dec=%0b, required 20/100/0 and 60/1",
                 s_hw[0], s_per[0], s_dec[0], s_hw[5], s_dec[5]);
      end
    end
  endtask

  task automatic test_threshold();
    logic [15:0] thr_seq[4];
    logic        dec_exp[4];
    thr_seq = '{16'd50, 16'd51, 16'd0, 16'hFFFF};
    dec_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
    restart();
    threshold_val = 16'd50;
    seg(1'b0, 20, 1'b1);
    seg(1'b1, 50, 1'b1); seg(1'b0, 50, 1'b1);
    for (int i = 0; i < 4; i++) begin
      threshold_val = thr_seq[i];
      if (i < 3) begin seg(1'b1, 50, 1'b1); seg(1'b0, 50, 1'b1); end
      else seg(1'b1, LAT + 5, 1'b1);
    end
    total++;
    if (s_cyc.size() != 4) begin
      bad++;
      $display("FAIL thr_count: got %0d samples, required 4", s_cyc.size());
    end
    for (int i = 0; i < 4 && i < s_cyc.size(); i++) begin
      total++;
      if (s_dec[i] !== dec_exp[i] || s_hw[i] !== 16'd50 || s_per[i] !== 16'd100) begin
        bad++;
        $display("FAIL thr_decode[%0d] thr=%0d: got dec=%0b hw=%0d per=%0d, required dec=%0b hw=50 per=100",
                 i, thr_seq[i], s_dec[i], s_hw[i], s_per[i], dec_exp[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int fc;
    int exp_fc;
    bit got;
    restart();
    threshold_val = 16'd50;
    timeout_val   = 16'd200;
    seg(1'b0, 20, 1'b1);
    seg(1'b1, 30, 1'b1); seg(1'b0, 70, 1'b1);
    seg(1'b1, 30, 1'b1);
    seg(1'b0, 1, 1'b1);
    exp_fc = r_cyc[r_cyc.size()-1] + LAT + 200;
    fc = -1;
    for (int i = 0; i < 400; i++) begin
      if (timeout_flag === 1'b1) begin fc = cyc; break; end
      @(negedge clk);
    end
    total++;
    if (fc != exp_fc) begin
      bad++;
      $display("FAIL timeout_time: got flag at cycle %0d, required cycle %0d", fc, exp_fc);
    end
    total++;
    if (busy !== 1'b0 || high_width !== 16'd30 || period !== 16'd100 || s_cyc.size() != 1) begin
      bad++;
      $display("FAIL timeout_hold: got busy=%0b hw=%0d per=%0d samples=%0d, required busy=0 hw=30 per=100 samples=1",
               busy, high_width, period, s_cyc.size());
    end
    seg(1'b0, 20, 1'b1);
    seg(1'b1, 40, 1'b1); seg(1'b0, 60, 1'b1);
    total++;
    if (timeout_flag !== 1'b1) begin
      bad++;
      $display("FAIL timeout_sticky: got flag=%0b before new sample, required 1", timeout_flag);
    end
    seg(1'b1, 1, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (sample_valid === 1'b1) begin
        got = 1'b1;
        total++;
        if (timeout_flag !== 1'b0 || high_width !== 16'd40 || period !== 16'd100) begin
          bad++;
          $display("FAIL timeout_clear: got flag=%0b hw=%0d per=%0d, required flag=0 hw=40 per=100",
                   timeout_flag, high_width, period);
        end
      end else @(negedge clk);
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL timeout_restart: got no sample_valid within 20 cycles, required one");
    end
  endtask

  task automatic test_mid_disable();
    restart();
    threshold_val = 16'd50;
    seg(1'b0, 20, 1'b1);
    seg(1'b1, 40, 1'b1); seg(1'b0, 60, 1'b1);
    seg(1'b1, 10, 1'b1);
    total++;
    if (high_width !== 16'd40 || busy !== 1'b1) begin
      bad++;
      $display("FAIL disable_pre: got hw=%0d busy=%0b, required hw=40 busy=1", high_width, busy);
    end
    capture_enabled = 1'b0;
    @(negedge clk);
    total++;
    if ({high_width, period, decoded_value, sample_valid, timeout_flag, busy} !== 36'd0) begin
      bad++;
      $display("FAIL disable_clear: got hw=%0d per=%0d dec=%0b sv=%0b tmo=%0b busy=%0b, required all 0",
               high_width, period, decoded_value, sample_valid, timeout_flag, busy);
    end
    capture_enabled = 1'b1;
    clear_rec();
    seg(1'b1, 30, 1'b1);
    seg(1'b0, 60, 1'b1);
    seg(1'b1, 40, 1'b1); seg(1'b0, 60, 1'b1);
    seg(1'b1, LAT + 5, 1'b1);
    build_expected();
    total++;
    if (s_cyc.size() != 1 || e_cyc.size() != 1) begin
      bad++;
      $display("FAIL reenable_count: got %0d samples (model %0d), required 1", s_cyc.size(), e_cyc.size());
    end else begin
      total++;
      if (s_cyc[0] != e_cyc[0] || s_hw[0] !== e_hw[0] || s_per[0] !== e_per[0]) begin
        bad++;
        $display("FAIL reenable_sample: got cyc=%0d hw=%0d per=%0d, required cyc=%0d hw=%0d per=%0d",
                 s_cyc[0], s_hw[0], s_per[0], e_cyc[0], e_hw[0], e_per[0]);
      end
    end
  endtask

  task automatic test_glitch();
    int shorts;
    restart();
    threshold_val = 16'd50;
    seg(1'b0, 20, 1'b1);
    for (int p = 0; p < 3; p++) begin
      seg(1'b1, 20, 1'b1); seg(1'b0, 30, 1'b1);
      seg(1'b1, 2, GREC);  seg(1'b0, 48, GREC);
    end
    seg(1'b1, LAT + 5, 1'b1);
    build_expected();
    total++;
    if (s_cyc.size() != e_cyc.size()) begin
      bad++;
      $display("FAIL glitch_count: got %0d samples, required %0d", s_cyc.size(), e_cyc.size());
    end
    for (int i = 0; i < e_cyc.size() && i < s_cyc.size(); i++) begin
      total++;
      if (s_cyc[i] != e_cyc[i] || s_hw[i] !== e_hw[i] || s_per[i] !== e_per[i] || s_dec[i] !== e_dec[i]) begin
        bad++;
        $display("FAIL glitch_sample[%0d]: got cyc=%0d hw=%0d per=%0d dec=%0b, required cyc=%0d hw=%0d per=%0d dec=%0b",
                 i, s_cyc[i], s_hw[i], s_per[i], s_dec[i], e_cyc[i], e_hw[i], e_per[i], e_dec[i]);
      end
    end
    shorts = 0;
    foreach (s_hw[i]) if (s_hw[i] == 16'd2) shorts++;
    total++;
    if (shorts != (GREC ? 3 : 0)) begin
      bad++;
      $display("FAIL glitch_short: got %0d short samples, required %0d", shorts, GREC ? 3 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_clean_train();
    test_random_train();
    test_threshold();
    test_timeout();
    test_mid_disable();
    test_glitch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
